cdc_event_scheduler: RTL and testbench

- Shares one bundled-data 4-phase req/ack crossing between N_CH event sources in the aclk domain.
- Captures single-cycle event pulses into sticky pending bits and selects one pending channel per transfer, round-robin.
- Drives xreq with a stable channel id (xid) and completes the full 4-phase handshake against an asynchronous xack returned from the destination domain.
- Sits in front of the destination-side ack synchronizer / edge detector; reports lost events and stuck handshakes.

---
 rtl/cdc_sched_pkg.sv | 40 ++++
 rtl/cdc_sync_bit.sv | 27 ++
 rtl/cdc_event_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_cdc_event_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_sched_pkg.sv
// Shared types and helpers for the event scheduler.
//   state_e : handshake FSM states (IDLE, REQ, DROP, ABORT)
//   pick_t  : result of the round-robin search (valid flag + channel id)
//   rr_pick : round-robin search that starts one past the last grant and wraps
package cdc_sched_pkg;

  localparam int MAX_CH   = 16;
  localparam int MAX_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DROP  = 2'd2,
    ABORT = 2'd3
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } pick_t;

  // Candidates are visited in the order last+1, last+2, ... modulo n_ch.
  // The first pending candidate wins. Bits at or above n_ch are never looked at.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0]   pending,
                                    input logic [MAX_ID_W-1:0] last,
                                    input int                  n_ch);
    pick_t               r;
    logic [MAX_ID_W-1:0] idx;
    r = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      idx = MAX_ID_W'((int'(last) + k) % n_ch);
      if (k <= n_ch && !r.valid && pending[idx]) begin
        r.valid = 1'b1;
        r.id    = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level signal.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears every stage to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output, STAGES clock edges of latency
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_event_scheduler.sv
// Round-robin scheduler that funnels N_CH single-cycle event pulses through one
// bundled-data 4-phase req/ack crossing.
//
// Handshake: xid is set up while xreq=0 and is held for as long as xreq=1.
// The sequence per transfer is xreq rise -> xack rise -> xreq fall -> xack fall;
// a transfer counts as complete (done pulse) only after xack has fallen again.
// xack is asynchronous and is only ever used after the synchronizer (xack_s).
//
// Ports:
//   aclk, aresetn     : clock, asynchronous active-low reset
//   ev, ev_mask       : event pulses and per-channel enables
//   xreq, xid, xack   : crossing request, bundled channel id, async acknowledge
//   busy              : FSM not in IDLE
//   done, done_id     : one-cycle completion pulse and its channel
//   overflow          : sticky per-channel "event arrived while already pending"
//   timeout_err       : sticky "a handshake phase ran out of time"
//   err_clr           : clears overflow and timeout_err
//   dbg_state         : current FSM state
module cdc_event_scheduler
  import cdc_sched_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int ID_W           = $clog2(N_CH),
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [N_CH-1:0] ev,
  input  logic [N_CH-1:0] ev_mask,
  output logic            xreq,
  output logic [ID_W-1:0] xid,
  input  logic            xack,
  output logic            busy,
  output logic            done,
  output logic [ID_W-1:0] done_id,
  output logic [N_CH-1:0] overflow,
  output logic            timeout_err,
  input  logic            err_clr,
  output state_e          dbg_state
);

  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int CNT_W   = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);

  state_e            state_q, state_d;
  logic              xreq_q, xreq_d;
  logic [ID_W-1:0]   xid_q, xid_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [N_CH-1:0]   overflow_q, overflow_d;
  logic              timeout_q, timeout_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              xack_s;
  logic [N_CH-1:0]   ev_in;
  logic [N_CH-1:0]   clr;
  logic              grant;
  logic              to_hit;
  logic              to_set;
  pick_t             pick;
  logic [ID_W-1:0]   winner;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_xack_sync (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .d_i    (xack),
    .q_o    (xack_s)
  );

  assign ev_in  = ev & ev_mask;
  assign to_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));

  always_comb begin
    pick   = rr_pick(MAX_CH'(pending_q), MAX_ID_W'(last_grant_q), N_CH);
    winner = ID_W'(pick.id);
  end

  // Handshake FSM: next state and registered outputs.
  always_comb begin
    state_d   = state_q;
    xreq_d    = xreq_q;
    xid_d     = xid_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    grant     = 1'b0;
    to_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A late xack from an aborted transfer blocks new grants.
        if (pick.valid && !xack_s) begin
          grant   = 1'b1;
          xid_d   = winner;
          xreq_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (xack_s) begin
          xreq_d  = 1'b0;
          state_d = DROP;
        end else if (to_hit) begin
          to_set  = 1'b1;
          xreq_d  = 1'b0;
          state_d = ABORT;
        end
      end
      DROP: begin
        if (!xack_s) begin
          done_d    = 1'b1;
          done_id_d = xid_q;
          state_d   = IDLE;
        end else if (to_hit) begin
          to_set  = 1'b1;
          state_d = ABORT;
        end
      end
      ABORT: begin
        xreq_d = 1'b0;
        if (!xack_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending/overflow/error bookkeeping. A fresh event on the channel being
  // granted this cycle re-arms pending instead of counting as overflow.
  always_comb begin
    clr          = grant ? (N_CH'(1) << winner) : '0;
    pending_d    = (pending_q & ~clr) | ev_in;
    overflow_d   = (err_clr ? '0 : overflow_q) | (ev_in & pending_q & ~clr);
    timeout_d    = err_clr ? 1'b0 : (timeout_q | to_set);
    last_grant_d = grant ? winner : last_grant_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == REQ || state_q == DROP) && !to_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      xreq_q       <= 1'b0;
      xid_q        <= '0;
      done_q       <= 1'b0;
      done_id_q    <= '0;
      pending_q    <= '0;
      overflow_q   <= '0;
      timeout_q    <= 1'b0;
      last_grant_q <= ID_W'(N_CH - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      xreq_q       <= xreq_d;
      xid_q        <= xid_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign xreq        = xreq_q;
  assign xid         = xid_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cdc_event_scheduler.sv
module tb_cdc_event_scheduler;
  import cdc_sched_pkg::*;

  localparam int N_CH = 4;
  localparam int ID_W = 2;

  // ---------------- clock / reset ----------------
  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N_CH-1:0] ev = '0;
  logic [N_CH-1:0] ev_mask = '1;
  logic            xreq;
  logic [ID_W-1:0] xid;
  logic            xack;
  logic            busy;
  logic            done;
  logic [ID_W-1:0] done_id;
  logic [N_CH-1:0] overflow;
  logic            timeout_err;
  logic            err_clr = 1'b0;
  state_e          dbg_state;

  always #5 aclk = ~aclk;

  cdc_event_scheduler #(
    .N_CH(N_CH), .ID_W(ID_W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .ev(ev), .ev_mask(ev_mask),
    .xreq(xreq), .xid(xid), .xack(xack), .busy(busy), .done(done),
    .done_id(done_id), .overflow(overflow), .timeout_err(timeout_err),
    .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // Destination model: either echoes xreq (immediate responder) or holds a
  // manually driven level.
  logic resp_auto = 1'b0;
  logic xack_man  = 1'b0;
  always @(negedge aclk) xack = resp_auto ? xreq : xack_man;

  // ---------------- scoreboard ----------------
  int              errors = 0;
  int              checks = 0;
  logic [ID_W-1:0] got_q[$];
  logic [ID_W-1:0] exp_q[$];

  always @(negedge aclk) if (aresetn === 1'b1 && done === 1'b1) got_q.push_back(done_id);

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset;
    aresetn   = 1'b0;
    ev        = '0;
    ev_mask   = '1;
    err_clr   = 1'b0;
    resp_auto = 1'b0;
    xack_man  = 1'b0;
    repeat (2) tick;
    aresetn = 1'b1;
    tick;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_ev(input logic [N_CH-1:0] v);
    ev = v;
    tick;
    ev = '0;
  endtask

  task automatic wait_dones(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset;
    checks++; if (xreq !== 1'b0) begin errors++; $display("FAIL reset_xreq: got %b want 0", xreq); end
    checks++; if (xid !== 2'd0) begin errors++; $display("FAIL reset_xid: got %0d want 0", xid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL reset_done_id: got %0d want 0", done_id); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL reset_overflow: got %b want 0000", overflow); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_single;
    bit stable_ok;
    do_reset;
    pulse_ev(4'b0100);
    checks++; if (xreq !== 1'b0) begin errors++; $display("FAIL single_xreq_t1: got %b want 0", xreq); end
    tick;
    checks++; if (xreq !== 1'b1 || xid !== 2'd2) begin errors++; $display("FAIL single_grant: got xreq=%b xid=%0d want xreq=1 xid=2", xreq, xid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    stable_ok = 1'b1;
    repeat (4) begin
      tick;
      if (xreq !== 1'b1 || xid !== 2'd2) stable_ok = 1'b0;
    end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL single_stable: got %b want 1", stable_ok); end
    xack_man = 1'b1;
    tick; tick;
    checks++; if (xreq !== 1'b1) begin errors++; $display("FAIL single_xreq_hold: got %b want 1", xreq); end
    tick;
    checks++; if (xreq !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_xreq_fall: got xreq=%b busy=%b want 0 1", xreq, busy); end
    xack_man = 1'b0;
    tick; tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b want 0", done); end
    tick;
    checks++; if (done !== 1'b1 || done_id !== 2'd2) begin errors++; $display("FAIL single_done: got done=%b id=%0d want 1 2", done, done_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    tick;
    checks++; if (done !== 1'b0 || done_id !== 2'd2) begin errors++; $display("FAIL single_done_pulse: got done=%b id=%0d want 0 2", done, done_id); end
  endtask

  task automatic test_round_robin;
    bit ok;
    do_reset;
    resp_auto = 1'b1;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    pulse_ev(4'b1111);
    wait_dones(4, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr4_wait: got %0d dones want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr4_seq[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
    exp_q = '{2'd0, 2'd3};
    pulse_ev(4'b1001);
    wait_dones(2, ok);
    repeat (20) tick;
    checks++; if (ok !== 1'b1 || got_q.size() != 2) begin errors++; $display("FAIL rr2_count: got %0d dones want 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr2_seq[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back;
    bit seen;
    do_reset;
    resp_auto = 1'b1;
    pulse_ev(4'b0011);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      tick;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", seen); end
    checks++; if (xreq !== 1'b0) begin errors++; $display("FAIL b2b_gap: got xreq=%b want 0", xreq); end
    tick;
    checks++; if (xreq !== 1'b1 || xid !== 2'd1) begin errors++; $display("FAIL b2b_next: got xreq=%b xid=%0d want 1 1", xreq, xid); end
  endtask

  task automatic test_overflow;
    bit ok;
    do_reset;
    pulse_ev(4'b0001);
    pulse_ev(4'b0010);
    pulse_ev(4'b0010);
    checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_set: got %b want 0010", overflow); end
    resp_auto = 1'b1;
    exp_q = '{2'd0, 2'd1};
    wait_dones(2, ok);
    repeat (20) tick;
    checks++; if (ok !== 1'b1 || got_q.size() != 2) begin errors++; $display("FAIL ovf_count: got %0d dones want 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_seq[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    err_clr = 1'b1; tick; err_clr = 1'b0;
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_clr: got %b want 0000", overflow); end

    // New event exactly on the grant edge of the same channel.
    do_reset;
    pulse_ev(4'b0011);
    tick;
    xack_man = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin tick; if (xreq === 1'b0) begin ok = 1'b1; break; end end
    xack_man = 1'b0;
    for (int c = 0; c < 10 && ok; c++) begin tick; if (done === 1'b1) break; end
    checks++; if (done !== 1'b1 || done_id !== 2'd0) begin errors++; $display("FAIL ovf_hs0_done: got done=%b id=%0d want 1 0", done, done_id); end
    pulse_ev(4'b0010);
    checks++; if (xreq !== 1'b1 || xid !== 2'd1) begin errors++; $display("FAIL ovf_grant1: got xreq=%b xid=%0d want 1 1", xreq, xid); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_coincide: got %b want 0000", overflow); end
    resp_auto = 1'b1;
    exp_q = '{2'd0, 2'd1, 2'd1};
    wait_dones(3, ok);
    repeat (20) tick;
    checks++; if (ok !== 1'b1 || got_q.size() != 3) begin errors++; $display("FAIL ovf_coincide_count: got %0d dones want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_coincide_seq[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mask;
    bit ok;
    do_reset;
    ev_mask = 4'b1110;
    pulse_ev(4'b0001);
    tick;
    pulse_ev(4'b0001);
    repeat (4) tick;
    checks++; if (xreq !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mask_idle: got xreq=%b busy=%b want 0 0", xreq, busy); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL mask_ovf: got %b want 0000", overflow); end
    // Pending bits survive a later mask change.
    ev_mask = 4'b1111;
    pulse_ev(4'b0011);
    tick;
    ev_mask = 4'b0000;
    resp_auto = 1'b1;
    exp_q = '{2'd0, 2'd1};
    wait_dones(2, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mask_keep_count: got %0d dones want 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mask_keep_seq[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    ev_mask = 4'b1111;
  endtask

  task automatic test_timeout;
    bit hold_ok;
    do_reset;
    pulse_ev(4'b0011);
    tick;
    checks++; if (xreq !== 1'b1 || xid !== 2'd0) begin errors++; $display("FAIL to_grant0: got xreq=%b xid=%0d want 1 0", xreq, xid); end
    hold_ok = 1'b1;
    repeat (15) begin
      tick;
      if (xreq !== 1'b1 || timeout_err !== 1'b0) hold_ok = 1'b0;
    end
    checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL to_req_hold: got %b want 1", hold_ok); end
    tick;
    checks++; if (timeout_err !== 1'b1 || xreq !== 1'b0) begin errors++; $display("FAIL to_fire: got err=%b xreq=%b want 1 0", timeout_err, xreq); end
    checks++; if (dbg_state !== ABORT) begin errors++; $display("FAIL to_abort: got %0d want %0d", dbg_state, ABORT); end
    tick;
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL to_idle: got %0d want %0d", dbg_state, IDLE); end
    tick;
    checks++; if (xreq !== 1'b1 || xid !== 2'd1) begin errors++; $display("FAIL to_next: got xreq=%b xid=%0d want 1 1", xreq, xid); end
    xack_man = 1'b1;
    err_clr = 1'b1; tick; err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clr: got %b want 0", timeout_err); end
    repeat (40) tick;
    checks++; if (dbg_state !== ABORT || busy !== 1'b1 || xreq !== 1'b0) begin errors++; $display("FAIL to_stuck: got state=%0d busy=%b xreq=%b want %0d 1 0", dbg_state, busy, xreq, ABORT); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_drop_fire: got %b want 1", timeout_err); end
    xack_man = 1'b0;
    repeat (4) tick;
    checks++; if (dbg_state !== IDLE || busy !== 1'b0) begin errors++; $display("FAIL to_release: got state=%0d busy=%b want %0d 0", dbg_state, busy, IDLE); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL to_no_done: got %0d dones want 0", got_q.size()); end
    err_clr = 1'b1; tick; err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clr2: got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid_req;
    do_reset;
    pulse_ev(4'b0101);
    tick;
    checks++; if (xreq !== 1'b1 || xid !== 2'd0) begin errors++; $display("FAIL mid_grant: got xreq=%b xid=%0d want 1 0", xreq, xid); end
    pulse_ev(4'b0100);
    checks++; if (overflow !== 4'b0100) begin errors++; $display("FAIL mid_ovf: got %b want 0100", overflow); end
    aresetn = 1'b0;
    #2;
    checks++; if (xreq !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async: got xreq=%b busy=%b want 0 0", xreq, busy); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL mid_async_ovf: got %b want 0000", overflow); end
    tick;
    aresetn = 1'b1;
    repeat (4) tick;
    checks++; if (xreq !== 1'b0) begin errors++; $display("FAIL mid_pending_clr: got xreq=%b want 0", xreq); end
    pulse_ev(4'b1001);
    tick;
    checks++; if (xreq !== 1'b1 || xid !== 2'd0) begin errors++; $display("FAIL mid_first_grant: got xreq=%b xid=%0d want 1 0", xreq, xid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_back_to_back;
    test_overflow;
    test_mask;
    test_timeout;
    test_reset_mid_req;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
